// File: rtl/ahb_lite_master_if.sv
// Signal bundle between the AHB-Lite master and its surroundings: command in, AHB bus, response out.
// master modport is the engine's view, slave modport is the view of whoever drives commands and the bridge.
interface ahb_lite_master_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic [DATA_W-1:0] HRDATA;

  logic              rsp_valid;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [CNT_W-1:0]  xfer_cnt;
  logic              err;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, HREADY, HRDATA,
    output cmd_ready, HSEL, HADDR, HWRITE, HWDATA,
           rsp_valid, rsp_write, rsp_rdata, xfer_cnt, err
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, HREADY, HRDATA,
    input  cmd_ready, HSEL, HADDR, HWRITE, HWDATA,
           rsp_valid, rsp_write, rsp_rdata, xfer_cnt, err
  );
endinterface

// File: rtl/ahb_lite_master.sv
// Two-stage (address/data) pipelined AHB-Lite initiator with a command/response front end.
// Optional stall timeout with sticky err is enabled by defining TIMEOUT_EN.
module ahb_lite_master #(
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                HCLK,
  input  logic                RESET_n,
  ahb_lite_master_if.master   bus
);

  logic              a_valid;
  logic              a_write;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;

  logic              d_valid;
  logic              d_write;
  logic [DATA_W-1:0] hwdata_q;

  logic              rsp_valid_q;
  logic              rsp_write_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [CNT_W-1:0]  xfer_cnt_q;

  logic              accept;
  logic              complete;
  logic              flush;
  logic              err_q;

  assign bus.cmd_ready = bus.HREADY & ~err_q;
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign complete      = bus.HREADY & d_valid;

  assign bus.HSEL      = a_valid;
  assign bus.HADDR     = a_addr;
  assign bus.HWRITE    = a_write;
  assign bus.HWDATA    = hwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.xfer_cnt  = xfer_cnt_q;
  assign bus.err       = err_q;

`ifdef TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] stall_cnt;

  // The stall that would make the count reach TIMEOUT_CYCLES aborts the pipeline instead.
  assign flush = d_valid & ~bus.HREADY & (stall_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      if (bus.HREADY || flush) begin
        stall_cnt <= '0;
      end else if (d_valid) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic timeout_unused;

  assign flush          = 1'b0;
  assign err_q          = 1'b0;
  assign timeout_unused = |TIMEOUT_CYCLES;
`endif

  // Address phase: address/direction hold when idle so only HSEL signals validity.
  always_ff @(posedge HCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      a_valid <= 1'b0;
      a_write <= 1'b0;
      a_addr  <= '0;
      a_wdata <= '0;
    end else if (flush) begin
      a_valid <= 1'b0;
    end else if (bus.HREADY) begin
      a_valid <= accept;
      if (accept) begin
        a_write <= bus.cmd_write;
        a_addr  <= bus.cmd_addr;
        a_wdata <= bus.cmd_wdata;
      end
    end
  end

  // HWDATA only changes when a write enters the data phase, so reads never expose stale-vs-new data.
  always_ff @(posedge HCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      d_valid  <= 1'b0;
      d_write  <= 1'b0;
      hwdata_q <= '0;
    end else if (flush) begin
      d_valid <= 1'b0;
    end else if (bus.HREADY) begin
      d_valid <= a_valid;
      d_write <= a_write;
      if (a_valid && a_write) begin
        hwdata_q <= a_wdata;
      end
    end
  end

  always_ff @(posedge HCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      rsp_valid_q <= complete;
      if (complete) begin
        rsp_write_q <= d_write;
        rsp_rdata_q <= d_write ? '0 : bus.HRDATA;
        xfer_cnt_q  <= xfer_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed self-checking bench for ahb_lite_master (4-bit transfer counter so wrap is reachable).
// Covers reset, single/back-to-back transfers, wait states, mid-transfer reset, counter wrap and stalls.
module tb_ahb_lite_master;

  logic clk;
  logic rst_n;
  int   tests;
  int   failures;
  int   pulses;

  ahb_lite_master_if #(.ADDR_W(7), .DATA_W(32), .CNT_W(4)) bus ();

  ahb_lite_master #(
    .ADDR_W(7), .DATA_W(32), .CNT_W(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .HCLK    (clk),
    .RESET_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic valid, input logic write,
                                input logic [6:0] addr, input logic [31:0] wdata);
    bus.cmd_valid = valid;
    bus.cmd_write = write;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
  endtask

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    tests    = 0;
    failures = 0;
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'h0;
    apply_stimulus(1'b1, 1'b1, 7'h25, 32'hDEADBEEF);

    // Reset held with a command pending
    repeat (5) step();
    check_output("rst_hsel",   32'(bus.HSEL), 0);
    check_output("rst_haddr",  32'(bus.HADDR), 0);
    check_output("rst_hwrite", 32'(bus.HWRITE), 0);
    check_output("rst_hwdata", bus.HWDATA, 0);
    check_output("rst_rsp",    32'(bus.rsp_valid), 0);
    check_output("rst_rdata",  bus.rsp_rdata, 0);
    check_output("rst_cnt",    32'(bus.xfer_cnt), 0);
    check_output("rst_err",    32'(bus.err), 0);

    // Single write
    rst_n = 1'b1;
    step();
    check_output("wr_hsel",   32'(bus.HSEL), 1);
    check_output("wr_haddr",  32'(bus.HADDR), 32'h25);
    check_output("wr_hwrite", 32'(bus.HWRITE), 1);
    apply_stimulus(1'b0, 1'b0, 7'h00, 32'h0);
    step();
    check_output("wr_hsel_off", 32'(bus.HSEL), 0);
    check_output("wr_hwdata",   bus.HWDATA, 32'hDEADBEEF);
    check_output("wr_rsp_early", 32'(bus.rsp_valid), 0);
    step();
    check_output("wr_rsp",     32'(bus.rsp_valid), 1);
    check_output("wr_rsp_dir", 32'(bus.rsp_write), 1);
    check_output("wr_rdata",   bus.rsp_rdata, 0);
    check_output("wr_cnt",     32'(bus.xfer_cnt), 1);
    step();
    check_output("wr_rsp_pulse", 32'(bus.rsp_valid), 0);

    // Back-to-back write, read, write
    apply_stimulus(1'b1, 1'b1, 7'h03, 32'h11);
    step();
    check_output("b2b_a0_addr", 32'(bus.HADDR), 32'h03);
    apply_stimulus(1'b1, 1'b0, 7'h43, 32'hFFFF_FFFF);
    step();
    check_output("b2b_a1_addr",  32'(bus.HADDR), 32'h43);
    check_output("b2b_a1_write", 32'(bus.HWRITE), 0);
    check_output("b2b_hwdata0",  bus.HWDATA, 32'h11);
    apply_stimulus(1'b1, 1'b1, 7'h63, 32'h22);
    step();
    check_output("b2b_rsp0",      32'(bus.rsp_valid), 1);
    check_output("b2b_rsp0_dir",  32'(bus.rsp_write), 1);
    check_output("b2b_hwdata_rd", bus.HWDATA, 32'h11);
    check_output("b2b_a2_addr",   32'(bus.HADDR), 32'h63);
    apply_stimulus(1'b0, 1'b0, 7'h00, 32'h0);
    bus.HRDATA = 32'hCAFE0043;
    step();
    bus.HRDATA = 32'h0;
    check_output("b2b_rsp1",      32'(bus.rsp_valid), 1);
    check_output("b2b_rsp1_dir",  32'(bus.rsp_write), 0);
    check_output("b2b_rsp1_data", bus.rsp_rdata, 32'hCAFE0043);
    check_output("b2b_hwdata1",   bus.HWDATA, 32'h22);
    check_output("b2b_hsel_off",  32'(bus.HSEL), 0);
    step();
    check_output("b2b_rsp2",      32'(bus.rsp_valid), 1);
    check_output("b2b_rsp2_dir",  32'(bus.rsp_write), 1);
    check_output("b2b_rsp2_data", bus.rsp_rdata, 0);
    check_output("b2b_cnt",       32'(bus.xfer_cnt), 4);
    step();
    check_output("b2b_idle", 32'(bus.rsp_valid), 0);

    // Wait states with a write queued behind a read
    apply_stimulus(1'b1, 1'b0, 7'h10, 32'h0);
    step();
    apply_stimulus(1'b1, 1'b1, 7'h55, 32'h33);
    step();
    bus.HREADY = 1'b0;
    #1;
    check_output("ws_cmd_ready", 32'(bus.cmd_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("ws_hsel",   32'(bus.HSEL), 1);
      check_output("ws_haddr",  32'(bus.HADDR), 32'h55);
      check_output("ws_hwrite", 32'(bus.HWRITE), 1);
      check_output("ws_hwdata", bus.HWDATA, 32'h22);
      check_output("ws_rsp",    32'(bus.rsp_valid), 0);
      check_output("ws_ready",  32'(bus.cmd_ready), 0);
    end
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'h12345678;
    apply_stimulus(1'b0, 1'b0, 7'h00, 32'h0);
    step();
    bus.HRDATA = 32'h0;
    check_output("ws_rsp_rd",   32'(bus.rsp_valid), 1);
    check_output("ws_rsp_data", bus.rsp_rdata, 32'h12345678);
    check_output("ws_hwdata_w", bus.HWDATA, 32'h33);
    check_output("ws_cnt_rd",   32'(bus.xfer_cnt), 5);
    step();
    check_output("ws_rsp_wr",   32'(bus.rsp_valid), 1);
    check_output("ws_cnt_wr",   32'(bus.xfer_cnt), 6);
    step();
    check_output("ws_idle", 32'(bus.rsp_valid), 0);

    // Reset while a write is in flight
    apply_stimulus(1'b1, 1'b1, 7'h7F, 32'hAA);
    step();
    check_output("mid_hsel_pre", 32'(bus.HSEL), 1);
    apply_stimulus(1'b0, 1'b0, 7'h00, 32'h0);
    rst_n = 1'b0;
    #1;
    check_output("mid_hsel_async", 32'(bus.HSEL), 0);
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.rsp_valid) pulses++;
    end
    check_output("mid_no_rsp", 32'(pulses), 0);
    check_output("mid_cnt",    32'(bus.xfer_cnt), 0);

    // 17 writes wrap a 4-bit counter to 1
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 17) apply_stimulus(1'b1, 1'b1, 7'(i), 32'(i));
      else        apply_stimulus(1'b0, 1'b0, 7'h00, 32'h0);
      step();
      if (bus.rsp_valid) pulses++;
      if (i == 17) check_output("wrap_cnt16", 32'(bus.xfer_cnt), 0);
    end
    check_output("wrap_pulses", 32'(pulses), 17);
    check_output("wrap_cnt",    32'(bus.xfer_cnt), 1);

    // Long stall of a read in its data phase
    apply_stimulus(1'b1, 1'b0, 7'h20, 32'h0);
    step();
    apply_stimulus(1'b0, 1'b0, 7'h00, 32'h0);
    step();
    bus.HREADY = 1'b0;
`ifdef TIMEOUT_EN
    repeat (15) step();
    check_output("to_err_pre", 32'(bus.err), 0);
    step();
    check_output("to_err",  32'(bus.err), 1);
    check_output("to_hsel", 32'(bus.HSEL), 0);
    bus.HREADY = 1'b1;
    apply_stimulus(1'b1, 1'b1, 7'h01, 32'h5);
    #1;
    check_output("to_ready", 32'(bus.cmd_ready), 0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.rsp_valid || bus.HSEL) pulses++;
    end
    check_output("to_quiet", 32'(pulses), 0);
    check_output("to_err_sticky", 32'(bus.err), 1);
    apply_stimulus(1'b0, 1'b0, 7'h00, 32'h0);
    rst_n = 1'b0;
    #1;
    check_output("to_err_clr", 32'(bus.err), 0);
    step();
    rst_n = 1'b1;
    step();
`else
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.rsp_valid) pulses++;
    end
    check_output("stall_no_rsp", 32'(pulses), 0);
    check_output("stall_err",    32'(bus.err), 0);
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'hBEEF;
    step();
    bus.HRDATA = 32'h0;
    check_output("stall_rsp",  32'(bus.rsp_valid), 1);
    check_output("stall_data", bus.rsp_rdata, 32'hBEEF);
    check_output("stall_cnt",  32'(bus.xfer_cnt), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
